// File: rtl/dmem_pkg.sv
// Shared types for the sized data memory: access-size encodings, FSM states
// and the byte-count helper.
package dmem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE  = 2'd0,
        SZ_HALF  = 2'd1,
        SZ_WORD  = 2'd2,
        SZ_DWORD = 2'd3
    } size_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_e;

    function automatic logic [3:0] size_bytes(input logic [1:0] sz);
        return 4'd1 << sz;
    endfunction

endpackage

// File: rtl/dmem_sized_hs_if.sv
// Request/response bundle between the load/store unit (master) and the data memory (slave).
interface dmem_sized_hs_if #(
    parameter int unsigned ADDR_W = 64,
    parameter int unsigned DATA_W = 64
);
    logic              MemoryRead;
    logic              MemoryWrite;
    logic [ADDR_W-1:0] Address;
    logic [1:0]        Size;
    logic              SignExt;
    logic [DATA_W-1:0] WriteData;
    logic              Ready;
    logic              Done;
    logic [DATA_W-1:0] ReadData;
    logic              Fault;

    modport master (
        output MemoryRead, MemoryWrite, Address, Size, SignExt, WriteData,
        input  Ready, Done, ReadData, Fault
    );

    modport slave (
        input  MemoryRead, MemoryWrite, Address, Size, SignExt, WriteData,
        output Ready, Done, ReadData, Fault
    );
endinterface

// File: rtl/dmem_lane_align.sv
// Byte-lane steering: packs an 8-byte memory window into a right-justified,
// extended load value, and spreads store data onto per-byte write lanes.
// DMEM_LITTLE_ENDIAN_EN selects little-endian ordering; default is big-endian.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [63:0] win_i,      // memory byte (Address + i) at [8*i +: 8]
    input  logic [1:0]  size_i,
    input  logic        sign_ext_i,
    input  logic [63:0] wdata_i,
    output logic [63:0] rdata_o,
    output logic [63:0] wbytes_o,   // byte for (Address + i) at [8*i +: 8]
    output logic [7:0]  be_o
);

    logic [3:0]  nbytes;
    logic [63:0] field;
    logic        msb;

    always_comb begin
        nbytes   = size_bytes(size_i);
        field    = '0;
        wbytes_o = '0;
        be_o     = '0;
        for (int i = 0; i < 8; i++) begin
            if (i < int'(nbytes)) begin
`ifdef DMEM_LITTLE_ENDIAN_EN
                field[8*i +: 8]    = win_i[8*i +: 8];
                wbytes_o[8*i +: 8] = wdata_i[8*i +: 8];
`else
                field[8*(int'(nbytes)-1-i) +: 8] = win_i[8*i +: 8];
                wbytes_o[8*i +: 8]               = wdata_i[8*(int'(nbytes)-1-i) +: 8];
`endif
                be_o[i] = 1'b1;
            end
        end
        msb     = field[8*int'(nbytes)-1];
        rdata_o = field;
        if (sign_ext_i && msb) begin
            for (int i = 0; i < 8; i++) begin
                if (i >= int'(nbytes)) rdata_o[8*i +: 8] = 8'hff;
            end
        end
    end

endmodule

// File: rtl/dmem_sized_hs.sv
// Sized, latency-configurable data memory with Ready/Done handshake and fault reporting.
// DMEM_LITTLE_ENDIAN_EN switches accesses and the preset image to little-endian.
module dmem_sized_hs
    import dmem_pkg::*;
#(
    parameter int unsigned ADDR_W  = 64,
    parameter int unsigned DATA_W  = 64,
    parameter int unsigned DEPTH   = 1024,
    parameter int unsigned LATENCY = 2
) (
    input logic             Clock,
    input logic             ResetL,
    dmem_sized_hs_if.slave  bus
);

    localparam int unsigned IdxW    = $clog2(DEPTH);
    localparam int unsigned AddrW1  = ADDR_W + 1;
    localparam logic [3:0]  CntInit = 4'(LATENCY - 1);

    function automatic logic [DEPTH*8-1:0] preset_image();
        logic [DEPTH*8-1:0] img;
        logic [63:0]        words [5];
        img   = '0;
        words = '{64'h1, 64'ha, 64'h5, 64'h0ffbea7deadbeeff, 64'h0};
        for (int w = 0; w < 5; w++) begin
            for (int j = 0; j < 8; j++) begin
`ifdef DMEM_LITTLE_ENDIAN_EN
                img[(w*8+j)*8 +: 8] = words[w][8*j +: 8];
`else
                img[(w*8+j)*8 +: 8] = words[w][8*(7-j) +: 8];
`endif
            end
        end
        return img;
    endfunction

    // Power-on contents only; reset deliberately leaves storage alone.
    logic [DEPTH*8-1:0] mem_q = preset_image();

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [IdxW-1:0]   addr_q;
    logic [1:0]        size_q;
    logic              sext_q;
    logic [DATA_W-1:0] wdata_q;
    logic              rd_q, wr_q, fault_q;
    logic [63:0]       rdata_q, rdata_d;

    logic              accept;
    logic              fault_now;
    logic [3:0]        nbytes;
    logic [ADDR_W:0]   end_addr;
    logic [IdxW-1:0]   lane_idx [8];
    logic [63:0]       win;
    logic [63:0]       aligned;
    logic [63:0]       wbytes;
    logic [7:0]        be;

    assign accept = (state_q == IDLE) && (bus.MemoryRead || bus.MemoryWrite);

    // End address is one bit wider than the bus so a huge address cannot wrap into range.
    always_comb begin
        nbytes    = size_bytes(bus.Size);
        end_addr  = {1'b0, bus.Address} + AddrW1'(nbytes);
        fault_now = (bus.MemoryRead && bus.MemoryWrite)
                  || ((bus.Address[3:0] & (nbytes - 4'd1)) != 4'd0)
                  || (end_addr > AddrW1'(DEPTH));
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if (LATENCY == 1) begin
                        state_d = RESP;
                        cnt_d   = '0;
                    end else begin
                        state_d = BUSY;
                        cnt_d   = CntInit;
                    end
                end
            end
            BUSY: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_d == 4'd0) state_d = RESP;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        win = '0;
        for (int i = 0; i < 8; i++) begin
            lane_idx[i]     = addr_q + IdxW'(i);
            win[8*i +: 8]   = mem_q[{lane_idx[i], 3'b000} +: 8];
        end
    end

    dmem_lane_align u_lane_align (
        .win_i      (win),
        .size_i     (size_q),
        .sign_ext_i (sext_q),
        .wdata_i    (wdata_q),
        .rdata_o    (aligned),
        .wbytes_o   (wbytes),
        .be_o       (be)
    );

    always_comb begin
        rdata_d = rdata_q;
        if (state_q == RESP) begin
            if (fault_q)   rdata_d = '0;
            else if (rd_q) rdata_d = aligned;
        end
    end

    always_ff @(posedge Clock or negedge ResetL) begin
        if (!ResetL) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            size_q  <= '0;
            sext_q  <= 1'b0;
            wdata_q <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            fault_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            if (accept) begin
                addr_q  <= bus.Address[IdxW-1:0];
                size_q  <= bus.Size;
                sext_q  <= bus.SignExt;
                wdata_q <= bus.WriteData;
                rd_q    <= bus.MemoryRead && !bus.MemoryWrite;
                wr_q    <= bus.MemoryWrite && !bus.MemoryRead;
                fault_q <= fault_now;
            end
        end
    end

    // Commit on the edge that leaves RESP; an async reset earlier skips it.
    always_ff @(posedge Clock) begin
        if (state_q == RESP && wr_q && !fault_q) begin
            for (int i = 0; i < 8; i++) begin
                if (be[i]) mem_q[{lane_idx[i], 3'b000} +: 8] <= wbytes[8*i +: 8];
            end
        end
    end

    assign bus.Ready    = (state_q == IDLE);
    assign bus.Done     = (state_q == RESP);
    assign bus.Fault    = (state_q == RESP) && fault_q;
    assign bus.ReadData = (state_q != RESP) ? rdata_q :
                          fault_q           ? '0      :
                          rd_q              ? aligned : rdata_q;

endmodule

// File: tb/tb_dmem_sized_hs.sv
// Self-checking bench for dmem_sized_hs: directed spec cases plus randomized
// accesses checked against a byte-array reference model.
module tb_dmem_sized_hs;

    localparam int unsigned ADDR_W  = 64;
    localparam int unsigned DATA_W  = 64;
    localparam int unsigned DEPTH   = 1024;
    localparam int unsigned LATENCY = 2;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    logic [7:0] ref_mem [DEPTH];

    dmem_sized_hs_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    dmem_sized_hs #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .DEPTH   (DEPTH),
        .LATENCY (LATENCY)
    ) dut (
        .Clock  (clk),
        .ResetL (rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic int nb(input logic [1:0] sz);
        return 1 << sz;
    endfunction

    function automatic void model_preset();
        logic [63:0] w [5];
        w = '{64'h1, 64'ha, 64'h5, 64'h0ffbea7deadbeeff, 64'h0};
        for (int a = 0; a < DEPTH; a++) ref_mem[a] = 8'h00;
        for (int k = 0; k < 5; k++) begin
            for (int j = 0; j < 8; j++) begin
`ifdef DMEM_LITTLE_ENDIAN_EN
                ref_mem[k*8+j] = w[k][8*j +: 8];
`else
                ref_mem[k*8+j] = w[k][8*(7-j) +: 8];
`endif
            end
        end
    endfunction

    function automatic logic model_fault(input logic rd, input logic wr,
                                         input logic [63:0] a, input logic [1:0] sz);
        logic [64:0] e;
        e = {1'b0, a} + 65'(nb(sz));
        return (rd && wr) || ((a % 64'(nb(sz))) != 0) || (e > 65'(DEPTH));
    endfunction

    function automatic logic [63:0] model_read(input logic [63:0] a, input logic [1:0] sz,
                                               input logic se);
        logic [63:0] v;
        int          n;
        int          base;
        n    = nb(sz);
        base = int'(a[9:0]);
        v    = '0;
        for (int i = 0; i < n; i++) begin
`ifdef DMEM_LITTLE_ENDIAN_EN
            v = v | (64'(ref_mem[base+i]) << (8*i));
`else
            v = (v << 8) | 64'(ref_mem[base+i]);
`endif
        end
        if (se && n < 8 && v[8*n-1]) v = v | (~64'd0 << (8*n));
        return v;
    endfunction

    function automatic void model_write(input logic [63:0] a, input logic [1:0] sz,
                                        input logic [63:0] wd);
        int n;
        int base;
        n    = nb(sz);
        base = int'(a[9:0]);
        for (int i = 0; i < n; i++) begin
`ifdef DMEM_LITTLE_ENDIAN_EN
            ref_mem[base+i] = wd[8*i +: 8];
`else
            ref_mem[base+i] = wd[8*(n-1-i) +: 8];
`endif
        end
    endfunction

    // ---------------- driver (no checking) ----------------
    // Called just after a rising edge. lat = cycles from accept cycle to Done, -1 on timeout.
    task automatic access(input logic rd, input logic wr, input logic [63:0] a,
                          input logic [1:0] sz, input logic se, input logic [63:0] wd,
                          output logic [63:0] rdat, output logic flt, output int lat);
        int guard;
        guard = 0;
        while (!bus.Ready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        bus.MemoryRead  = rd;
        bus.MemoryWrite = wr;
        bus.Address     = a;
        bus.Size        = sz;
        bus.SignExt     = se;
        bus.WriteData   = wd;
        @(posedge clk); #1;
        bus.MemoryRead  = 1'b0;
        bus.MemoryWrite = 1'b0;
        lat = 1;
        while (!bus.Done && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        rdat = bus.ReadData;
        flt  = bus.Fault;
        if (!bus.Done) lat = -1;
        @(posedge clk); #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        bus.MemoryRead = 1'b0; bus.MemoryWrite = 1'b0; bus.Address = '0;
        bus.Size = 2'd0; bus.SignExt = 1'b0; bus.WriteData = '0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp += 4;
        if (bus.Ready !== 1'b1) begin n_err++; $display("FAIL reset_ready got=%b exp=1", bus.Ready); end
        if (bus.Done !== 1'b0) begin n_err++; $display("FAIL reset_done got=%b exp=0", bus.Done); end
        if (bus.Fault !== 1'b0) begin n_err++; $display("FAIL reset_fault got=%b exp=0", bus.Fault); end
        if (bus.ReadData !== 64'h0) begin
            n_err++; $display("FAIL reset_rdata got=%h exp=0", bus.ReadData);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    // Issues one access, checks latency/fault/data against the model, then updates the model.
    task automatic run_checked(input string name, input logic rd, input logic wr,
                               input logic [63:0] a, input logic [1:0] sz, input logic se,
                               input logic [63:0] wd);
        logic [63:0] rdat, exp_d;
        logic        flt, exp_f;
        int          lat;
        exp_f = model_fault(rd, wr, a, sz);
        exp_d = exp_f ? 64'h0 : (rd ? model_read(a, sz, se) : 64'h0);
        access(rd, wr, a, sz, se, wd, rdat, flt, lat);
        n_cmp += 2;
        if (lat !== int'(LATENCY)) begin
            n_err++; $display("FAIL %s latency got=%0d exp=%0d", name, lat, LATENCY);
        end
        if (flt !== exp_f) begin
            n_err++; $display("FAIL %s fault got=%b exp=%b", name, flt, exp_f);
        end
        if (exp_f || rd) begin
            n_cmp++;
            if (rdat !== exp_d) begin
                n_err++; $display("FAIL %s rdata got=%h exp=%h", name, rdat, exp_d);
            end
        end
        if (!exp_f && wr) model_write(a, sz, wd);
    endtask

    task automatic test_reads();
        run_checked("dword_0x18", 1, 0, 64'h18, 2'd3, 0, '0);
        run_checked("byte_0x1f_sx", 1, 0, 64'h1f, 2'd0, 1, '0);
        run_checked("byte_0x1f_zx", 1, 0, 64'h1f, 2'd0, 0, '0);
        run_checked("word_0x1c_sx", 1, 0, 64'h1c, 2'd2, 1, '0);
        run_checked("half_0x1a_zx", 1, 0, 64'h1a, 2'd1, 0, '0);
    endtask

    task automatic test_half_write();
        run_checked("half_wr_0x22", 0, 1, 64'h22, 2'd1, 0, 64'hdead_beef_cafe_1234);
        run_checked("dword_0x20", 1, 0, 64'h20, 2'd3, 0, '0);
    endtask

    task automatic test_faults();
        run_checked("word_0x1e_misal", 1, 0, 64'h1e, 2'd2, 1, '0);
        run_checked("dword_0x3f8_ok", 1, 0, 64'h3f8, 2'd3, 0, '0);
        run_checked("dword_0x3fc_bad", 1, 0, 64'h3fc, 2'd3, 0, '0);
        run_checked("byte_0x400_range", 1, 0, 64'h400, 2'd0, 0, '0);
        run_checked("dword_huge_range", 1, 0, 64'hffff_ffff_ffff_fff8, 2'd3, 0, '0);
        run_checked("rd_and_wr", 1, 1, 64'h0, 2'd3, 0, 64'h5555_5555_5555_5555);
        run_checked("misal_wr", 0, 1, 64'h9, 2'd1, 0, 64'hffff);
        run_checked("after_faults_0x0", 1, 0, 64'h0, 2'd3, 0, '0);
        run_checked("after_faults_0x8", 1, 0, 64'h8, 2'd3, 0, '0);
    endtask

    task automatic test_random();
        logic [63:0] a, wd;
        logic [1:0]  sz;
        logic        rd, wr, se;
        int          kind;
        for (int k = 0; k < 60; k++) begin
            sz   = 2'($urandom_range(0, 3));
            kind = $urandom_range(0, 19);
            rd   = 1'b1;
            wr   = 1'b0;
            if (kind < 8) begin rd = 1'b0; wr = 1'b1; end
            else if (kind == 8) wr = 1'b1;
            a = 64'($urandom_range(0, 127)) & ~(64'(nb(sz)) - 64'd1);
            if (kind == 9) a = 64'($urandom_range(0, DEPTH - 1));
            if (kind == 10) a = {32'($urandom), 32'($urandom)};
            if (kind == 11) a = 64'(DEPTH) - 64'($urandom_range(0, 7));
            se = 1'($urandom);
            wd = {32'($urandom), 32'($urandom)};
            run_checked("random", rd, wr, a, sz, se, wd);
        end
    endtask

    // MemoryRead held high; the address presented while busy must be ignored.
    task automatic test_back_to_back();
        logic [63:0] acc_addr, exp_d;
        int          last_acc, low_run, n_done, n_acc;
        logic [63:0] addrs [3];
        addrs    = '{64'h0, 64'h8, 64'h18};
        last_acc = -1;
        low_run  = 0;
        n_done   = 0;
        n_acc    = 0;
        acc_addr = '0;
        bus.MemoryRead = 1'b1; bus.MemoryWrite = 1'b0; bus.Size = 2'd3; bus.SignExt = 1'b0;
        for (int c = 0; c < 14; c++) begin
            if (bus.Done) begin
                n_done++;
                exp_d = model_read(acc_addr, 2'd3, 1'b0);
                n_cmp++;
                if (bus.ReadData !== exp_d) begin
                    n_err++; $display("FAIL b2b_rdata got=%h exp=%h", bus.ReadData, exp_d);
                end
            end
            if (bus.Ready) begin
                if (last_acc >= 0) begin
                    n_cmp += 2;
                    if (c - last_acc != int'(LATENCY) + 1) begin
                        n_err++;
                        $display("FAIL b2b_spacing got=%0d exp=%0d", c - last_acc, LATENCY + 1);
                    end
                    if (low_run != int'(LATENCY)) begin
                        n_err++; $display("FAIL b2b_ready_low got=%0d exp=%0d", low_run, LATENCY);
                    end
                end
                last_acc    = c;
                low_run     = 0;
                acc_addr    = addrs[n_acc % 3];
                bus.Address = acc_addr;
                n_acc++;
            end else begin
                low_run++;
                bus.Address = 64'h10 + 64'(c % 2);
            end
            @(posedge clk); #1;
        end
        bus.MemoryRead = 1'b0;
        while (!bus.Ready) begin @(posedge clk); #1; end
        n_cmp++;
        if (n_done < 3) begin n_err++; $display("FAIL b2b_done_count got=%0d exp>=3", n_done); end
    endtask

    task automatic test_reset_mid();
        int seen_done;
        seen_done = 0;
        bus.MemoryRead = 1'b0; bus.MemoryWrite = 1'b1; bus.Address = 64'h0;
        bus.Size = 2'd3; bus.SignExt = 1'b0; bus.WriteData = 64'haaaa_aaaa_aaaa_aaaa;
        @(posedge clk); #1;
        bus.MemoryWrite = 1'b0;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (bus.Ready !== 1'b1) begin n_err++; $display("FAIL midrst_ready got=%b exp=1", bus.Ready); end
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            if (c == 1) rst_n = 1'b1;
            if (bus.Done) seen_done++;
        end
        n_cmp++;
        if (seen_done != 0) begin n_err++; $display("FAIL midrst_done got=%0d exp=0", seen_done); end
        run_checked("midrst_read_0x0", 1, 0, 64'h0, 2'd3, 0, '0);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        model_preset();
        rst_n = 1'b0;
        test_reset();
        test_reads();
        test_half_write();
        test_faults();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/dmem_sized_hs.md
Name: dmem_sized_hs

Overview:
Parametrised successor to the single-cycle data memory. It is a byte-addressed, big-endian data memory that supports byte, half, word and doubleword accesses with optional sign extension, configurable access latency, and a ready/done handshake. It reports misaligned and out-of-range accesses as faults. It sits between the datapath load/store unit and the writeback mux, and is the memory the multi-cycle and pipelined cores use.

Parameters:
- ADDR_W, 64, address bus width.
- DATA_W, 64, data bus width; fixed at 64 (doubleword max access).
- DEPTH, 1024, memory size in bytes; power of two.
- LATENCY, 2, cycles from accept to Done; legal range 1..15.

Ports:
- Clock  in  1  rising-edge clock.
- ResetL  in  1  asynchronous active-low reset.
- MemoryRead  in  1  read request.
- MemoryWrite  in  1  write request.
- Address  in  ADDR_W  byte address of the most significant byte of the access.
- Size  in  2  access size: 0 byte, 1 half, 2 word, 3 doubleword.
- SignExt  in  1  sign-extend sub-doubleword reads.
- WriteData  in  DATA_W  store data; the low Size bytes are used.
- Ready  out  1  idle; a request is accepted this cycle.
- Done  out  1  one-cycle completion pulse.
- ReadData  out  DATA_W  load result; valid when Done is high on a read.
- Fault  out  1  qualifies Done; the access was rejected.

Behaviour:
- Reset (ResetL low, async): state IDLE, Ready=1, Done=0, Fault=0, ReadData=0, counter=0. Memory contents are not cleared.
- Preset image at time 0: 0x0=0x1, 0x8=0xa, 0x10=0x5, 0x18=0x0ffbea7deadbeeff, 0x20=0x0, each stored big-endian.
- Accept: a request is accepted on the rising edge where Ready=1 and (MemoryRead|MemoryWrite)=1. Address, Size, SignExt, WriteData and the operation are latched at that edge. Inputs are ignored when Ready=0.
- States:
  - IDLE: on accept, go to BUSY with counter=LATENCY-1. If LATENCY=1, go straight to RESP.
  - BUSY: decrement counter each cycle; go to RESP when counter reaches 0.
  - RESP: Done=1 for exactly one cycle, then return to IDLE. Ready=1 only in IDLE.
- Latency: Done rises exactly LATENCY cycles after the accepting edge. Back-to-back throughput is one access per LATENCY+1 cycles.
- Fault conditions, evaluated at accept:
  - MemoryRead and MemoryWrite both high.
  - Address not aligned to 2^Size bytes.
  - Address + 2^Size > DEPTH, computed in ADDR_W+1 bits so there is no wrap-around.
  - On a fault the access still walks through BUSY/RESP with identical timing. In RESP, Fault=1, ReadData=0 and memory is untouched.
- Read: byte at Address is the MSB of the field. The result is right-justified in ReadData and zero- or sign-extended from bit 8·2^Size−1. ReadData holds its value until the next read Done.
- Write: the low 2^Size bytes of the latched WriteData are stored, MSB at Address. The commit happens at the RESP edge only.
- Reset mid-operation: the transaction is aborted with no Done and no write commit.
- ReadData and Fault are meaningful only while Done=1; Fault=0 otherwise.

Optional Feature:
DMEM_LITTLE_ENDIAN_EN.
- Defined: the byte at Address is the LSB of the field, for accesses and for the preset image.
- Undefined: big-endian as above.
- Alignment, fault and timing rules are identical in both modes.

Decomposition:
- Package dmem_pkg:
  - Size encodings SZ_BYTE/SZ_HALF/SZ_WORD/SZ_DWORD.
  - State enum IDLE/BUSY/RESP.
  - Function giving the byte count for a Size value.
- One sub-module, dmem_lane_align: combinational extract, right-justify and sign/zero-extend for reads, plus byte-enable generation for writes. The FSM, storage and fault check stay in the top module.

Test Plan:
- Reset, then dword read at 0x18 with LATENCY=2 → Done exactly 2 cycles after accept, ReadData=0x0ffbea7deadbeeff, Fault=0.
- Byte read at 0x1F: SignExt=1 → 0xFFFFFFFFFFFFFFFF; SignExt=0 → 0x00000000000000FF. Word read at 0x1C, SignExt=1 → 0xFFFFFFFFEADBEEFF.
- Half write 0x1234 at 0x22, then dword read at 0x20 → 0x0000123400000000. Bytes 0x20, 0x21 and 0x24–0x27 are unchanged.
- Fault cases, each giving Done with Fault=1, ReadData=0 and memory unchanged:
  - Word read at 0x1E (misaligned).
  - Dword read at 0x3F8 with DEPTH=1024 → no fault. Dword read at 0x3FC → fault.
  - MemoryRead and MemoryWrite both high.
- Handshake: hold MemoryRead high continuously → Ready is low for LATENCY cycles, accepts are spaced LATENCY+1 cycles apart, and a request changed while busy is ignored.
- Reset mid-operation: assert ResetL low during BUSY of a dword write of 0xAAAA… to 0x0 → no Done, and a read at 0x0 returns 0x1.
